// File: rtl/dp_mem_responder_if.sv
// Request/response bundle for one memory port of dp_mem_responder.
//   read, write : request strobes (held by the initiator until resp)
//   wmask       : byte enables, bit0 -> [7:0], bit1 -> [15:8]
//   address     : byte address (bit 0 ignored)
//   wdata       : write data
//   resp        : one-cycle completion pulse
//   rdata       : read data, valid in the resp cycle and held afterwards
// master = initiator (core side), slave = responder (memory side).
interface dp_mem_responder_if;
    logic        read;
    logic        write;
    logic [1:0]  wmask;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        resp;
    logic [15:0] rdata;

    modport master (output read, write, wmask, address, wdata, input  resp, rdata);
    modport slave  (input  read, write, wmask, address, wdata, output resp, rdata);
endinterface

// File: rtl/dp_mem_responder.sv
// Dual-port fixed-latency memory responder (port A = fetch, port B = data).
// Each port runs an IDLE/BUSY/RESP FSM; the access commits on the edge that
// enters RESP, and resp is high for that one RESP cycle.
//   clk    : system clock
//   rst    : synchronous active-high reset (array contents are kept)
//   port_a : port A request/response bundle (slave side)
//   port_b : port B request/response bundle (slave side)
// Parameters: LATENCY (1..15) request-to-resp cycles, ADDR_BITS word depth log2.
module dp_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic               clk,
    input  logic               rst,
    dp_mem_responder_if.slave  port_a,
    dp_mem_responder_if.slave  port_b
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    // Port-indexed views of the two bundles (index 0 = A, 1 = B)
    logic [1:0]                     rd_in, wr_in;
    logic [1:0][1:0]                mask_in;
    logic [1:0][ADDR_BITS-1:0]      idx_in;
    logic [1:0][15:0]               wdata_in;

    assign rd_in    = {port_b.read,  port_a.read};
    assign wr_in    = {port_b.write, port_a.write};
    assign mask_in  = {port_b.wmask, port_a.wmask};
    assign idx_in   = {port_b.address[ADDR_BITS:1], port_a.address[ADDR_BITS:1]};
    assign wdata_in = {port_b.wdata, port_a.wdata};

    // Address bit 0 and bits above the word index alias away
    logic unused_addr;
    assign unused_addr = ^{port_a.address, port_b.address};

    // Commit-edge view of each port's access
    logic [1:0]                commit, c_wr, resp_q;
    logic [1:0][1:0]           c_mask;
    logic [1:0][ADDR_BITS-1:0] c_idx;
    logic [1:0][15:0]          c_wdata;
    logic [1:0][15:0]          rdata_q;

    logic [15:0] mem [DEPTH];

    for (genvar p = 0; p < 2; p++) begin : g_port
        state_t                 state, state_nxt;
        logic [3:0]             cnt, cnt_nxt;
        logic                   req, commit_l;
        logic                   lat_wr;
        logic [1:0]             lat_mask;
        logic [ADDR_BITS-1:0]   lat_idx;
        logic [15:0]            lat_wdata;

        assign req = rd_in[p] | wr_in[p];

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // read+write together is a write, so only the write strobe is kept
        always_ff @(posedge clk) begin
            if (rst) begin
                lat_wr    <= 1'b0;
                lat_mask  <= '0;
                lat_idx   <= '0;
                lat_wdata <= '0;
            end else if (state == IDLE && req) begin
                lat_wr    <= wr_in[p];
                lat_mask  <= mask_in[p];
                lat_idx   <= idx_in[p];
                lat_wdata <= wdata_in[p];
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            commit_l  = 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (LATENCY == 1) begin
                            state_nxt = RESP;
                            commit_l  = 1'b1;
                        end else begin
                            state_nxt = BUSY;
                            cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = RESP;
                        commit_l  = 1'b1;
                    end
                end
                RESP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        // With LATENCY=1 the commit happens on the accept edge itself, so the
        // live inputs must be used while still in IDLE.
        assign commit[p]  = commit_l;
        assign resp_q[p]  = (state == RESP);
        assign c_wr[p]    = (state == IDLE) ? wr_in[p]    : lat_wr;
        assign c_mask[p]  = (state == IDLE) ? mask_in[p]  : lat_mask;
        assign c_idx[p]   = (state == IDLE) ? idx_in[p]   : lat_idx;
        assign c_wdata[p] = (state == IDLE) ? wdata_in[p] : lat_wdata;
    end

    // Reads sample the array before this edge's writes land -> old data on
    // a same-edge read/write collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (commit[p] && !c_wr[p]) rdata_q[p] <= mem[c_idx[p]];
            end
        end
    end

    // Port B is applied after port A, so B wins on overlapping bytes while
    // A's non-overlapping bytes still land. In-flight commits die on rst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (commit[p] && c_wr[p]) begin
                    if (c_mask[p][0]) mem[c_idx[p]][7:0]  <= c_wdata[p][7:0];
                    if (c_mask[p][1]) mem[c_idx[p]][15:8] <= c_wdata[p][15:8];
                end
            end
        end
    end

    assign port_a.resp  = resp_q[0];
    assign port_b.resp  = resp_q[1];
    assign port_a.rdata = rdata_q[0];
    assign port_b.rdata = rdata_q[1];
endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: two instances (LATENCY=4 and LATENCY=1).
// Channel k: 0 = dut4 port A, 1 = dut4 port B, 2 = dut1 port A, 3 = dut1 port B.
// A transaction-level model predicts resp/rdata each cycle; directed
// sequences add literal expectations.
module tb_dp_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_rd [4];
    logic        in_wr [4];
    logic [1:0]  in_mask [4];
    logic [15:0] in_addr [4];
    logic [15:0] in_wdata [4];
    logic        mon_resp [4];
    logic [15:0] mon_rdata [4];

    dp_mem_responder_if b0 ();
    dp_mem_responder_if b1 ();
    dp_mem_responder_if b2 ();
    dp_mem_responder_if b3 ();

    assign b0.read = in_rd[0]; assign b0.write = in_wr[0]; assign b0.wmask = in_mask[0];
    assign b0.address = in_addr[0]; assign b0.wdata = in_wdata[0];
    assign b1.read = in_rd[1]; assign b1.write = in_wr[1]; assign b1.wmask = in_mask[1];
    assign b1.address = in_addr[1]; assign b1.wdata = in_wdata[1];
    assign b2.read = in_rd[2]; assign b2.write = in_wr[2]; assign b2.wmask = in_mask[2];
    assign b2.address = in_addr[2]; assign b2.wdata = in_wdata[2];
    assign b3.read = in_rd[3]; assign b3.write = in_wr[3]; assign b3.wmask = in_mask[3];
    assign b3.address = in_addr[3]; assign b3.wdata = in_wdata[3];
    assign mon_resp[0] = b0.resp; assign mon_rdata[0] = b0.rdata;
    assign mon_resp[1] = b1.resp; assign mon_rdata[1] = b1.rdata;
    assign mon_resp[2] = b2.resp; assign mon_rdata[2] = b2.rdata;
    assign mon_resp[3] = b3.resp; assign mon_rdata[3] = b3.rdata;

    dp_mem_responder #(.LATENCY(4), .ADDR_BITS(10)) dut4 (
        .clk(clk), .rst(rst), .port_a(b0), .port_b(b1));
    dp_mem_responder #(.LATENCY(1), .ADDR_BITS(10)) dut1 (
        .clk(clk), .rst(rst), .port_a(b2), .port_b(b3));

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // ---------------- transaction-level model ----------------
    // A request seen at edge n (port free) completes at edge n+LAT-1; resp
    // is high in the following cycle; the port can accept again at edge +2.
    int          lat [2] = '{4, 1};
    int          n = 0;
    bit          pend [4];
    int          cedge [4];
    int          nfree [4];
    bit          m_wr [4];
    logic [1:0]  m_mask [4];
    logic [9:0]  m_idx [4];
    logic [15:0] m_wdata [4];
    logic        exp_resp [4];
    logic [15:0] exp_rdata [4];
    logic [15:0] mmem [2][1024];

    initial begin
        for (int k = 0; k < 4; k++) begin
            pend[k] = 1'b0; nfree[k] = 0; cedge[k] = 0;
        end
        forever begin
            @(posedge clk);
            n++;
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    pend[k] = 1'b0; nfree[k] = n + 1;
                    exp_resp[k] = 1'b0; exp_rdata[k] = 16'h0000;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    exp_resp[k] = 1'b0;
                    if (!pend[k] && n >= nfree[k] && (in_rd[k] || in_wr[k])) begin
                        pend[k]    = 1'b1;
                        m_wr[k]    = in_wr[k];
                        m_mask[k]  = in_mask[k];
                        m_idx[k]   = in_addr[k][10:1];
                        m_wdata[k] = in_wdata[k];
                        cedge[k]   = n + lat[k/2] - 1;
                    end
                end
                // all reads of this edge see memory before any write
                for (int k = 0; k < 4; k++)
                    if (pend[k] && cedge[k] == n && !m_wr[k])
                        exp_rdata[k] = mmem[k/2][m_idx[k]];
                for (int k = 0; k < 4; k++) begin
                    if (pend[k] && cedge[k] == n) begin
                        if (m_wr[k]) begin
                            if (m_mask[k][0]) mmem[k/2][m_idx[k]][7:0]  = m_wdata[k][7:0];
                            if (m_mask[k][1]) mmem[k/2][m_idx[k]][15:8] = m_wdata[k][15:8];
                        end
                        exp_resp[k] = 1'b1;
                        pend[k]     = 1'b0;
                        nfree[k]    = n + 2;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int k = 0; k < 4; k++) begin
                    tests++;
                    if (mon_resp[k] !== exp_resp[k]) begin
                        fails++;
                        $display("FAIL model_resp ch%0d t=%0t: got %b expected %b", k, $time, mon_resp[k], exp_resp[k]);
                    end
                    tests++;
                    if (mon_rdata[k] !== exp_rdata[k]) begin
                        fails++;
                        $display("FAIL model_rdata ch%0d t=%0t: got %h expected %h", k, $time, mon_rdata[k], exp_rdata[k]);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request, hold until resp, drop it after the following edge.
    // cyc = number of edges from presentation until resp was seen.
    task automatic txn(input int k, input bit rd, input bit wr, input logic [1:0] mask,
                       input logic [15:0] addr, input logic [15:0] data, output int cyc);
        bit seen;
        in_rd[k] = rd; in_wr[k] = wr; in_mask[k] = mask;
        in_addr[k] = addr; in_wdata[k] = data;
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #2;
            cyc++;
            if (mon_resp[k]) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL timeout ch%0d addr %h: no resp within 40 cycles", k, addr);
        end
        @(posedge clk); #2;
        in_rd[k] = 1'b0; in_wr[k] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int cyc, cyc2, pulses, rsp_cnt;
        int at [3];
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_rd[k] = 1'b0; in_wr[k] = 1'b0; in_mask[k] = 2'b00;
            in_addr[k] = 16'h0000; in_wdata[k] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        #2; rst = 1'b0; chk_on = 1'b1;
        check("reset_resp_a", {15'h0, mon_resp[0]}, 16'h0000);
        check("reset_rdata_b", mon_rdata[1], 16'h0000);

        // preload, then a read so rdata_a is non-zero before the second reset
        txn(1, 0, 1, 2'b11, 16'h0010, 16'h1234, cyc);
        txn(0, 0, 1, 2'b11, 16'h0030, 16'h1111, cyc);
        txn(0, 1, 0, 2'b00, 16'h0030, 16'h0000, cyc);
        check("preload_read_0x30", mon_rdata[0], 16'h1111);

        rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        check("rst_rdata_a", mon_rdata[0], 16'h0000);
        check("rst_resp_b", {15'h0, mon_resp[1]}, 16'h0000);

        // latency and pulse width
        txn(1, 1, 0, 2'b00, 16'h0010, 16'h0000, cyc);
        check("lat4_cycles", 16'(cyc), 16'd4);
        check("lat4_rdata", mon_rdata[1], 16'h1234);
        check("resp_one_cycle", {15'h0, mon_resp[1]}, 16'h0000);

        // byte-masked writes on port B, and address aliasing
        txn(1, 0, 1, 2'b11, 16'h0020, 16'hBEEF, cyc);
        txn(1, 0, 1, 2'b10, 16'h0020, 16'h1200, cyc);
        txn(1, 1, 0, 2'b00, 16'h0020, 16'h0000, cyc);
        check("mask_merge", mon_rdata[1], 16'h12EF);
        txn(1, 1, 0, 2'b00, 16'h0021, 16'h0000, cyc);
        check("alias_bit0", mon_rdata[1], 16'h12EF);
        txn(1, 1, 0, 2'b00, 16'h0820, 16'h0000, cyc);
        check("alias_high", mon_rdata[1], 16'h12EF);

        // write/write collision
        txn(0, 0, 1, 2'b11, 16'h0040, 16'h0000, cyc);
        fork
            txn(0, 0, 1, 2'b11, 16'h0040, 16'hAAAA, cyc);
            txn(1, 0, 1, 2'b01, 16'h0040, 16'h5555, cyc2);
        join
        txn(0, 1, 0, 2'b00, 16'h0040, 16'h0000, cyc);
        check("ww_collision", mon_rdata[0], 16'hAA55);

        // read/write collision: A sees the old word
        fork
            txn(0, 1, 0, 2'b00, 16'h0040, 16'h0000, cyc);
            txn(1, 0, 1, 2'b11, 16'h0040, 16'h1357, cyc2);
        join
        check("rw_collision_old", mon_rdata[0], 16'hAA55);
        txn(0, 1, 0, 2'b00, 16'h0040, 16'h0000, cyc);
        check("rw_collision_after", mon_rdata[0], 16'h1357);

        // request held across three transactions
        in_rd[1] = 1'b1; in_wr[1] = 1'b0; in_addr[1] = 16'h0020;
        pulses = 0;
        for (int i = 1; i <= 20 && pulses < 3; i++) begin
            @(posedge clk); #2;
            if (mon_resp[1]) begin
                at[pulses] = i;
                pulses++;
            end
        end
        @(posedge clk); #2; in_rd[1] = 1'b0;
        check("held_pulses", 16'(pulses), 16'd3);
        check("held_first", 16'(at[0]), 16'd4);
        check("held_spacing1", 16'(at[1] - at[0]), 16'd5);
        check("held_spacing2", 16'(at[2] - at[1]), 16'd5);

        // address change while busy is ignored
        fork
            txn(1, 1, 0, 2'b00, 16'h0020, 16'h0000, cyc);
            begin
                @(posedge clk); #3;
                in_addr[1] = 16'h0040;
            end
        join
        check("mid_busy_addr", mon_rdata[1], 16'h12EF);

        // reset mid-BUSY abandons the write
        in_wr[0] = 1'b1; in_mask[0] = 2'b11; in_addr[0] = 16'h0030; in_wdata[0] = 16'hFFFF;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1; in_wr[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        rsp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (mon_resp[0]) rsp_cnt++;
            @(posedge clk); #2;
        end
        check("abandon_no_resp", 16'(rsp_cnt), 16'd0);
        txn(0, 1, 0, 2'b00, 16'h0030, 16'h0000, cyc);
        check("abandon_old_data", mon_rdata[0], 16'h1111);

        // LATENCY=1 instance
        txn(2, 0, 1, 2'b11, 16'h0055, 16'hCAFE, cyc);
        check("lat1_write_cycles", 16'(cyc), 16'd1);
        txn(3, 1, 0, 2'b00, 16'h0055, 16'h0000, cyc);
        check("lat1_read_cycles", 16'(cyc), 16'd1);
        check("lat1_read_data", mon_rdata[3], 16'hCAFE);
        // read+write with mask 00: a write that changes nothing
        txn(2, 1, 1, 2'b00, 16'h0055, 16'h0000, cyc);
        check("rw_both_is_write", mon_rdata[2], 16'h0000);
        txn(3, 1, 0, 2'b00, 16'h0055, 16'h0000, cyc);
        check("mask00_no_change", mon_rdata[3], 16'hCAFE);

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
